// File: rtl/mips_pkg.sv
// mips_pkg: shared loader state encodings and instruction memory sizing
package mips_pkg;

    localparam int IMEM_DEPTH = 50;
    localparam int INSTR_W    = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: shifts stream bytes MSB-first into a 32-bit instruction word
module word_assembler
    import mips_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               shift,
    input  logic [7:0]         in_data,
    output logic [INSTR_W-1:0] word,
    output logic               word_full
);

    logic [INSTR_W-9:0] sr;
    logic [1:0]         cnt;

    // Only the first three bytes are stored; the fourth is merged on the fly so
    // the finished word is available on the edge that accepts its last byte.
    assign word      = {sr, in_data};
    assign word_full = cnt == 2'd3;

    // Byte shift register and position counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift) begin
            sr  <= {sr[INSTR_W-17:0], in_data};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: streams a counted byte program into instruction memory
module instruction_loader
    import mips_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [15:0]        words_loaded
);

    localparam int          IDX_W   = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    loader_state_t      state, state_nxt;
    logic [15:0]        count;
    logic [IDX_W-1:0]   word_idx;
    logic [INSTR_W-1:0] asm_word;
    logic               word_full;
    logic               xfer;
    logic               launch;
    logic               last_word;
    logic [15:0]        cnt_full;

    assign xfer      = in_valid && in_ready;
    assign launch    = start && (state == IDLE || state == DONE || state == ERROR);
    assign cnt_full  = {count[15:8], in_data};
    assign last_word = (words_loaded + 16'd1) == count;

    word_assembler u_asm (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (launch),
        .shift     (xfer && state == DATA),
        .in_data   (in_data),
        .word      (asm_word),
        .word_full (word_full)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and Moore-decoded handshake/strobe outputs
    always_comb begin
        state_nxt = state;
        in_ready  = state == CNT_HI || state == CNT_LO || state == DATA;
        busy      = in_ready || state == WRITE;
        mem_we    = state == WRITE;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = CNT_HI;
            CNT_HI:            if (xfer) state_nxt = CNT_LO;
            CNT_LO:            if (xfer) state_nxt = cnt_full == 16'd0 ? DONE :
                                                     cnt_full > DEPTH16 ? ERROR : DATA;
            DATA:              if (xfer && word_full) state_nxt = WRITE;
            WRITE:             state_nxt = last_word ? DONE : DATA;
            default:           state_nxt = IDLE;
        endcase
    end

    // Count capture, word indexing, write port registers and status levels
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            word_idx     <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            if (launch) begin
                word_idx     <= '0;
                words_loaded <= '0;
                done         <= 1'b0;
                error        <= 1'b0;
            end
            if (state == CNT_HI && xfer) count[15:8] <= in_data;
            if (state == CNT_LO && xfer) begin
                count[7:0] <= in_data;
                done       <= cnt_full == 16'd0;
                error      <= cnt_full > DEPTH16;
            end
            // Write address/data are loaded as the word completes so they are
            // valid for the whole WRITE cycle and hold afterwards.
            if (state == DATA && xfer && word_full) begin
                mem_addr  <= ADDR_W'(word_idx);
                mem_wdata <= asm_word;
            end
            if (state == WRITE) begin
                word_idx     <= word_idx + 1'b1;
                words_loaded <= words_loaded + 16'd1;
                done         <= last_word;
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed self-checking bench for instruction_loader
module tb_instruction_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];

    instruction_loader #(.DEPTH(50), .ADDR_W(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mem_we) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_wdata);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, {in_ready, mem_we, busy, done, error}, 5'b0);
        check({tag, "_words"}, words_loaded, 16'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        tick(gap);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 200) begin
            tick(1);
            t++;
        end
        if (!in_ready) check("byte_timeout", in_ready, 1'b1);
        else tick(1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++)
            send_byte(w[31-8*i -: 8], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic send_count(input logic [15:0] c);
        send_byte(c[15:8], 0);
        send_byte(c[7:0], 0);
    endtask

    task automatic wait_not_busy(input string tag);
        int t;
        t = 0;
        in_valid = 1'b0;
        while (busy && t < 500) begin
            tick(1);
            t++;
        end
        if (busy) check({tag, "_busy_timeout"}, busy, 1'b0);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_addr"}, idx < q_addr.size() ? q_addr[idx] : 32'hffff_ffff, a);
        check({tag, "_data"}, idx < q_data.size() ? q_data[idx] : 32'hffff_ffff, d);
    endtask

    initial begin
        logic ready_seen;
        // Reset asserted mid-cycle, before any clock edge
        #2 reset_n = 1'b0;
        #1 check_zero("reset");
        tick(2);
        reset_n = 1'b1;
        ready_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = ~in_valid;
            in_data  = 8'(i);
            tick(1);
            ready_seen |= in_ready;
        end
        in_valid = 1'b0;
        check("idle_no_ready", ready_seen, 1'b0);

        // Single word
        clear_log();
        pulse_start();
        check("start_ready", in_ready, 1'b1);
        check("start_busy", busy, 1'b1);
        send_count(16'd1);
        send_word(32'h0880_1000, 0);
        check("single_we", mem_we, 1'b1);
        check("single_ready_low", in_ready, 1'b0);
        check("single_addr_live", mem_addr, 32'd0);
        check("single_data_live", mem_wdata, 32'h0880_1000);
        in_valid = 1'b0;
        tick(1);
        check("single_done", done, 1'b1);
        check("single_busy", busy, 1'b0);
        check("single_words", words_loaded, 16'd1);
        tick(2);
        check("single_pulses", q_addr.size(), 1);
        check("single_hold", mem_wdata, 32'h0880_1000);

        // Full depth with random source gaps
        clear_log();
        pulse_start();
        send_count(16'd50);
        for (int n = 0; n < 50; n++) send_word(32'h1000_0000 + n, 3);
        wait_not_busy("full");
        check("full_done", done, 1'b1);
        check("full_words", words_loaded, 16'd50);
        check("full_pulses", q_addr.size(), 50);
        for (int n = 0; n < 50; n++) check_log("full", n, n, 32'h1000_0000 + n);

        // Throughput without gaps
        clear_log();
        pulse_start();
        send_count(16'd3);
        for (int n = 0; n < 3; n++) send_word(32'hA000_0000 + n, 0);
        wait_not_busy("thru");
        check("thru_pulses", q_cyc.size(), 3);
        if (q_cyc.size() == 3) begin
            check("thru_gap01", q_cyc[1] - q_cyc[0], 5);
            check("thru_gap12", q_cyc[2] - q_cyc[1], 5);
        end

        // Count 51 rejected
        clear_log();
        pulse_start();
        send_count(16'h0033);
        check("cnt51_error", error, 1'b1);
        check("cnt51_busy", busy, 1'b0);
        check("cnt51_done", done, 1'b0);
        in_valid = 1'b1;
        tick(4);
        in_valid = 1'b0;
        check("cnt51_ready", in_ready, 1'b0);
        check("cnt51_pulses", q_addr.size(), 0);

        // Count 0 finishes immediately
        pulse_start();
        check("cnt0_err_clr", error, 1'b0);
        send_count(16'd0);
        check("cnt0_done", done, 1'b1);
        check("cnt0_busy", busy, 1'b0);
        in_valid = 1'b0;
        tick(3);
        check("cnt0_words", words_loaded, 16'd0);
        check("cnt0_pulses", q_addr.size(), 0);

        // Start during DATA is ignored
        clear_log();
        pulse_start();
        send_count(16'd2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        in_valid = 1'b0;
        pulse_start();
        check("restart_busy", busy, 1'b1);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_word(32'h5566_7788, 0);
        wait_not_busy("restart");
        check("restart_done", done, 1'b1);
        check("restart_words", words_loaded, 16'd2);
        check("restart_pulses", q_addr.size(), 2);
        check_log("restart0", 0, 0, 32'h1122_3344);
        check_log("restart1", 1, 1, 32'h5566_7788);

        // New start after done clears status and restarts at address 0
        clear_log();
        pulse_start();
        check("again_done_clr", done, 1'b0);
        check("again_words_clr", words_loaded, 16'd0);
        send_count(16'd1);
        send_word(32'hCAFE_F00D, 0);
        wait_not_busy("again");
        check("again_done", done, 1'b1);
        check_log("again", 0, 0, 32'hCAFE_F00D);

        // Reset mid-load after two of three words
        clear_log();
        pulse_start();
        send_count(16'd3);
        send_word(32'h0101_0101, 0);
        send_word(32'h0202_0202, 0);
        in_valid = 1'b0;
        tick(1);
        check("midrst_pre_pulses", q_addr.size(), 2);
        #2 reset_n = 1'b0;
        #1 check_zero("midrst");
        for (int i = 0; i < 6; i++) begin
            in_valid = ~in_valid;
            in_data  = 8'hEE;
            tick(1);
        end
        reset_n  = 1'b1;
        in_valid = 1'b1;
        tick(4);
        in_valid = 1'b0;
        check("midrst_idle_ready", in_ready, 1'b0);
        check("midrst_idle_busy", busy, 1'b0);
        check("midrst_pulses", q_addr.size(), 2);

        // Following full load succeeds
        clear_log();
        pulse_start();
        send_count(16'd2);
        send_word(32'hDEAD_BEEF, 1);
        send_word(32'h1234_5678, 1);
        wait_not_busy("post");
        check("post_done", done, 1'b1);
        check("post_words", words_loaded, 16'd2);
        check("post_pulses", q_addr.size(), 2);
        check_log("post0", 0, 0, 32'hDEAD_BEEF);
        check_log("post1", 1, 1, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
